// File: rtl/max_pool_unit.sv
// max_pool_unit: signed max of each POOL_K x POOL_K window via a registered compare tree,
// buffered in a first-word-fall-through FIFO and tagged with pooled (x, y). Rev 1.0
`default_nettype none

module max_pool_unit #(
  parameter int IF_BW         = 32,
  parameter int POOL_K        = 2,
  parameter int POOL_OUT_SIZE = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               i_window_valid,
  input  logic [POOL_K*POOL_K*IF_BW-1:0]     i_window,
  output logic                               o_out_valid,
  input  logic                               i_out_ready,
  output logic [IF_BW-1:0]                   o_out_pixel,
  output logic [$clog2(POOL_OUT_SIZE)-1:0]   o_out_x,
  output logic [$clog2(POOL_OUT_SIZE)-1:0]   o_out_y,
  output logic                               o_frame_done,
  output logic                               o_overflow
);

  localparam int N  = POOL_K * POOL_K;
  localparam int L  = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(POOL_OUT_SIZE);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] C_LAST   = CW'(POOL_OUT_SIZE - 1);

  function automatic int level_cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  // Level 0 is the raw window; each later level halves the element count,
  // an odd trailing element is forwarded unchanged.
  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int CNT = level_cnt(l);
    logic signed [IF_BW-1:0] data_q [CNT];
    logic                    vld_q;

    if (l == 0) begin : g_in
      for (genvar j = 0; j < CNT; j++) begin : g_el
        assign data_q[j] = i_window[j*IF_BW +: IF_BW];
      end
      assign vld_q = i_window_valid;
    end else begin : g_st
      localparam int PC = level_cnt(l - 1);
      for (genvar j = 0; j < CNT; j++) begin : g_el
        if (2*j + 1 < PC) begin : g_max
          always_ff @(posedge clk) begin
            data_q[j] <= (g_lvl[l-1].data_q[2*j] > g_lvl[l-1].data_q[2*j+1]) ?
                         g_lvl[l-1].data_q[2*j] : g_lvl[l-1].data_q[2*j+1];
          end
        end else begin : g_pass
          always_ff @(posedge clk) begin
            data_q[j] <= g_lvl[l-1].data_q[2*j];
          end
        end
      end
      always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) vld_q <= 1'b0;
        else         vld_q <= g_lvl[l-1].vld_q;
      end
    end
  end

  logic [IF_BW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic [CW-1:0]    x_q, x_d, y_q, y_d;
  logic             overflow_q;
  logic             push, full, pop, wr_en;

  assign push  = g_lvl[L].vld_q;
  assign full  = (count_q == FULL_CNT);
  assign pop   = o_out_valid && i_out_ready;
  // A full FIFO still accepts a result when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
  end

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (pop) begin
      if (x_q == C_LAST) begin
        x_d = '0;
        y_d = (y_q == C_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= g_lvl[L].data_q[0];
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (push && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign o_out_valid  = (count_q != '0);
  assign o_out_pixel  = o_out_valid ? mem_q[rd_ptr_q] : '0;
  assign o_out_x      = x_q;
  assign o_out_y      = y_q;
  assign o_frame_done = pop && (x_q == C_LAST) && (y_q == C_LAST);
  assign o_overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_max_pool_unit.sv
// Directed bench for max_pool_unit (IF_BW=32, POOL_K=2, POOL_OUT_SIZE=4, FIFO_DEPTH=4).
`default_nettype none

module tb_max_pool_unit;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_window_valid;
  logic [127:0] i_window;
  logic         o_out_valid;
  logic         i_out_ready;
  logic [31:0]  o_out_pixel;
  logic [1:0]   o_out_x;
  logic [1:0]   o_out_y;
  logic         o_frame_done;
  logic         o_overflow;

  max_pool_unit #(
    .IF_BW(32), .POOL_K(2), .POOL_OUT_SIZE(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_window_valid(i_window_valid), .i_window(i_window),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_pixel(o_out_pixel),
    .o_out_x(o_out_x), .o_out_y(o_out_y), .o_frame_done(o_frame_done), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] win;
    logic [31:0]  exp;
  } vec_t;

  vec_t tab [9];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [127:0] mkwin(input int e0, input int e1, input int e2, input int e3);
    return {32'(e3), 32'(e2), 32'(e1), 32'(e0)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [127:0] w);
    i_window_valid = 1'b1;
    i_window       = w;
  endtask

  task automatic idle();
    i_window_valid = 1'b0;
    i_window       = '0;
  endtask

  initial begin
    int k;
    logic [31:0] exp_q [4];

    tab[0] = '{mkwin(5, -3, 17, 2),                                 32'd17};
    tab[1] = '{mkwin(-8, -1, -20, -7),                              32'hFFFF_FFFF};
    tab[2] = '{mkwin(-8, 3, -8, -8),                                32'd3};
    tab[3] = '{mkwin(32'h7FFF_FFFF, 32'h8000_0000, 0, 1),           32'h7FFF_FFFF};
    tab[4] = '{mkwin(-2, -2, -2, -2),                               32'hFFFF_FFFE};
    tab[5] = '{mkwin(9, 1, 1, 1),                                   32'd9};
    tab[6] = '{mkwin(1, 1, 1, 9),                                   32'd9};
    tab[7] = '{mkwin(-100, -50, -75, -60),                          32'hFFFF_FFCE};
    tab[8] = '{mkwin(32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000), 32'h8000_0001};

    reset_n = 1'b1;
    i_out_ready = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_valid", o_out_valid, 0);
    chk("rst_pixel", o_out_pixel, 0);
    chk("rst_x", o_out_x, 0);
    chk("rst_y", o_out_y, 0);
    chk("rst_frame_done", o_frame_done, 0);
    chk("rst_overflow", o_overflow, 0);
    reset_n = 1'b0;
    tick();

    // Single windows, one at a time: exact 3-cycle latency, value and tag.
    i_out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(tab[i].win);
      tick();
      idle();
      chk("lat_e1_valid", o_out_valid, 0);
      tick();
      chk("lat_e2_valid", o_out_valid, 0);
      tick();
      chk("lat_e3_valid", o_out_valid, 1);
      chk("vec_pixel", o_out_pixel, tab[i].exp);
      chk("vec_x", o_out_x, i % 4);
      chk("vec_y", o_out_y, i / 4);
      chk("vec_frame_done", o_frame_done, 0);
      tick();
      chk("vec_drop_valid", o_out_valid, 0);
    end

    reset_n = 1'b1;
    #1;
    chk("async_rst_x", o_out_x, 0);
    chk("async_rst_y", o_out_y, 0);
    tick();
    reset_n = 1'b0;
    tick();

    // Full frame, back-to-back, no backpressure.
    k = 0;
    for (int c = 0; c < 30; c++) begin
      if (o_out_valid) begin
        chk("frame_pixel", o_out_pixel, k);
        chk("frame_x", o_out_x, k % 4);
        chk("frame_y", o_out_y, k / 4);
        chk("frame_done", o_frame_done, (k == 15) ? 1 : 0);
        k++;
      end
      if (c < 16) drive(mkwin(-5, -5, -5, c));
      else        idle();
      tick();
    end
    chk("frame_count", k, 16);
    chk("frame_wrap_x", o_out_x, 0);
    chk("frame_wrap_y", o_out_y, 0);
    chk("frame_empty", o_out_valid, 0);

    // Backpressure and overflow.
    i_out_ready = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      drive(mkwin(v*10, -1, 0, v*10 - 5));
      tick();
    end
    idle();
    repeat (4) tick();
    chk("bp_overflow_clear", o_overflow, 0);
    chk("bp_valid", o_out_valid, 1);
    chk("bp_head", o_out_pixel, 10);
    drive(mkwin(0, 50, 1, 2));
    tick();
    idle();
    repeat (4) tick();
    chk("bp_overflow_set", o_overflow, 1);
    chk("bp_head_hold", o_out_pixel, 10);
    chk("bp_x_hold", o_out_x, 0);
    exp_q = '{32'd10, 32'd20, 32'd30, 32'd40};
    i_out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_out_valid) begin
        chk("bp_pixel", o_out_pixel, (k < 4) ? exp_q[k] : 32'hDEAD_BEEF);
        k++;
      end
      tick();
    end
    chk("bp_count", k, 4);
    chk("bp_overflow_sticky", o_overflow, 1);

    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    tick();

    // Full FIFO with a push and pop landing on the same edge.
    i_out_ready = 1'b0;
    for (int v = 11; v <= 14; v++) begin
      drive(mkwin(0, 0, v, 1));
      tick();
    end
    idle();
    repeat (4) tick();
    chk("pp_head", o_out_pixel, 11);
    drive(mkwin(99, 98, -99, 0));
    tick();
    idle();
    tick();
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    chk("pp_no_overflow", o_overflow, 0);
    chk("pp_new_head", o_out_pixel, 12);
    chk("pp_x", o_out_x, 1);
    exp_q = '{32'd12, 32'd13, 32'd14, 32'd99};
    i_out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      if (o_out_valid) begin
        chk("pp_pixel", o_out_pixel, (k < 4) ? exp_q[k] : 32'hDEAD_BEEF);
        k++;
      end
      tick();
    end
    chk("pp_count", k, 4);
    chk("pp_overflow_final", o_overflow, 0);

    // Reset with two results queued and two windows in the tree.
    i_out_ready = 1'b0;
    drive(mkwin(61, 0, 0, 0));
    tick();
    drive(mkwin(62, 0, 0, 0));
    tick();
    idle();
    tick();
    tick();
    drive(mkwin(63, 0, 0, 0));
    tick();
    drive(mkwin(64, 0, 0, 0));
    tick();
    idle();
    chk("mr_pre_valid", o_out_valid, 1);
    chk("mr_pre_x", o_out_x, 1);
    reset_n = 1'b1;
    #1;
    chk("mr_valid", o_out_valid, 0);
    chk("mr_pixel", o_out_pixel, 0);
    chk("mr_x", o_out_x, 0);
    chk("mr_y", o_out_y, 0);
    chk("mr_frame_done", o_frame_done, 0);
    chk("mr_overflow", o_overflow, 0);
    tick();
    tick();
    reset_n = 1'b0;
    i_out_ready = 1'b1;
    drive(mkwin(7, -7, 3, 0));
    tick();
    idle();
    chk("mr_e1_valid", o_out_valid, 0);
    tick();
    chk("mr_e2_valid", o_out_valid, 0);
    tick();
    chk("mr_e3_valid", o_out_valid, 1);
    chk("mr_e3_pixel", o_out_pixel, 7);
    chk("mr_e3_x", o_out_x, 0);
    chk("mr_e3_y", o_out_y, 0);
    tick();
    chk("mr_after_valid", o_out_valid, 0);
    tick();
    chk("mr_no_stale", o_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/max_pool_unit.md
# max_pool_unit

Downstream consumer of the pooling line buffer. It takes each `POOL_K`×`POOL_K` window the line buffer emits and reduces it to its signed maximum through a registered comparator tree. Results go into a small output FIFO with ready/valid backpressure. The block tags every output pixel with its pooled (x, y) coordinate and pulses a frame-done flag when the last pooled pixel of a frame leaves.

## Interface
Parameters:
- `IF_BW`, 32: pixel width, signed two's complement.
- `POOL_K`, 2: window edge; window holds `POOL_K*POOL_K` pixels.
- `POOL_OUT_SIZE`, 4: pooled output is `POOL_OUT_SIZE`×`POOL_OUT_SIZE` per frame.
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `reset_n`, input, 1: asynchronous, **active-high** reset. The name follows codebase convention; the polarity is high.
- `i_window_valid`, input, 1: window present this cycle. There is no upstream ready; windows cannot be stalled.
- `i_window`, input, `POOL_K*POOL_K*IF_BW`: element (wy,wx) at bits `[(wy*POOL_K+wx)*IF_BW +: IF_BW]`.
- `o_out_valid`, output, 1: FIFO head valid.
- `i_out_ready`, input, 1: downstream accepts the head this cycle.
- `o_out_pixel`, output, `IF_BW`: head max value.
- `o_out_x`, output, `$clog2(POOL_OUT_SIZE)`: pooled column of the head.
- `o_out_y`, output, `$clog2(POOL_OUT_SIZE)`: pooled row of the head.
- `o_frame_done`, output, 1: one-cycle pulse on the handshake of pooled pixel (`POOL_OUT_SIZE-1`, `POOL_OUT_SIZE-1`).
- `o_overflow`, output, 1: sticky flag; set when a result was dropped.

## Operation
- **Comparator tree**
  - Depth is `L = ceil(log2(POOL_K*POOL_K))` register stages (L=2 for K=2).
  - Each stage takes the pairwise signed max of the previous level.
  - An odd leftover element passes through unchanged.
  - A valid bit travels alongside each stage. The tree never stalls.
- **Output FIFO**
  - The final stage's valid writes the result into the FIFO.
  - The FIFO is first-word-fall-through: `o_out_pixel` reflects the head whenever `o_out_valid`=1.
  - Pop occurs when `o_out_valid && i_out_ready`.
  - Push when not full: the result is stored.
  - Push when full with no pop in the same cycle: the result is dropped and `o_overflow` is set to 1. It holds until reset.
  - Push and pop together when full: both happen, the count is unchanged, and there is no overflow.
  - Push and pop together when empty: the pushed entry becomes head next cycle. There is no bypass.
- **Coordinate counters**
  - `o_out_x`/`o_out_y` advance on each pop.
  - x wraps `POOL_OUT_SIZE-1`→0 and increments y.
  - y wraps `POOL_OUT_SIZE-1`→0, which starts a new frame.
  - `o_frame_done` is asserted combinationally with the pop of the pixel at x=y=`POOL_OUT_SIZE-1`.
  - Dropped results do not advance the counters.
- **Reset**
  - Asserting `reset_n` at any time clears: tree valids, FIFO pointers and count, counters, and `o_overflow`.
  - In-flight windows are discarded.
  - Data registers need not reset.

## Timing
- Reset values:
  - `o_out_valid`=0, `o_out_pixel`=0, `o_out_x`=0, `o_out_y`=0, `o_frame_done`=0, `o_overflow`=0.
  - Reset takes effect immediately (asynchronous). Operation resumes on the first edge after deassertion.
- Latency: window at edge N → `o_out_valid`=1 after edge N+L+1 (3 cycles for K=2), provided the FIFO was empty.
- Throughput: one window per cycle sustained while `i_out_ready`=1.
- Worst-case FIFO occupancy with no backpressure is 1.
- `o_out_pixel`, `o_out_x` and `o_out_y` hold stable while `o_out_valid`=1 and `i_out_ready`=0.
- Windows may arrive on any cycle pattern, including consecutive cycles.

## Test plan
- **Single window, positive max:** {5,−3,17,2}, `i_out_ready`=1.
  - `o_out_valid`=1 exactly 3 cycles later.
  - `o_out_pixel`=17, x=0, y=0, then valid drops.
- **All-negative window:** {−8,−1,−20,−7}.
  - `o_out_pixel`=0xFFFFFFFF (−1). Confirms signed compare; an unsigned compare would yield −1 as well, so also test {−8, 3} mixes and expect 3.
- **Full frame:** 16 back-to-back windows with values 0..15 in element 3, ready=1.
  - 16 outputs in order.
  - Coordinates (0,0)…(3,3) row-major.
  - `o_frame_done` pulses only on the 16th.
  - Counters return to (0,0).
- **Backpressure:** ready=0, 4 windows {max 10,20,30,40}.
  - FIFO full, `o_overflow`=0.
  - A 5th window {max 50} is dropped and `o_overflow`=1.
  - Raise ready: outputs are 10,20,30,40 only, and `o_overflow` stays 1.
- **Full with simultaneous push and pop:** FIFO holds 4 entries, ready=1 in the same cycle a new result {max 99} arrives.
  - No overflow.
  - 99 appears after the 3 remaining entries.
- **Mid-stream reset:** assert `reset_n`=1 while 2 windows are in the tree and 2 are in the FIFO.
  - All outputs are 0 in the same cycle.
  - After release, the next window produces x=0, y=0 with 3-cycle latency.
